// File: rtl/sine_sample_capture.sv
// Captures decimated (optionally mid-scale triggered) sine samples into a FIFO for CPU readout
// over an Avalon-MM CSR window; level interrupt when the programmed window has been captured.
module sine_sample_capture #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              ChipSelect,
    input  logic              Write,
    input  logic              Read,
    input  logic [1:0]        Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [DATA_W-1:0] iData_sin,
    input  logic              iSample_tick,
    output logic              oIrq
);

    localparam logic [1:0]        A_CTRL   = 2'd0;
    localparam logic [1:0]        A_STATUS = 2'd1;
    localparam logic [1:0]        A_DATA   = 2'd2;
    localparam logic [1:0]        A_LEN    = 2'd3;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic                trig_en_q, trig_en_d;
    logic                irq_en_q, irq_en_d;
    logic [7:0]          decim_q, decim_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     captured_q, captured_d;
    logic [7:0]          decim_cnt_q, decim_cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic                rd_en;
    logic                start_req;
    logic                clear_req;
    logic                fifo_empty;
    logic                fifo_full;
    logic                tick_acc;
    logic                trigger;
    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic [ADDR_W:0]     eff_len;
    logic [ADDR_W:0]     captured_inc;
    logic [31:0]         status_word;
    logic [31:0]         ctrl_word;
    logic                unused_wdata;

    assign unused_wdata = ^WriteData[31:16];

    assign wr_en      = ChipSelect & Write;
    assign rd_en      = ChipSelect & Read;
    assign start_req  = wr_en && (Address == A_CTRL) && WriteData[0];
    assign clear_req  = wr_en && (Address == A_CTRL) && WriteData[1];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign eff_len    = ((len_q == '0) || (len_q > DEPTH_C)) ? DEPTH_C : len_q;
    assign tick_acc   = iSample_tick && (decim_cnt_q == decim_q);
    assign trigger    = prev_valid_q && (prev_q < MID) && (iData_sin >= MID);
    assign captured_inc = captured_q + 1'b1;

    always_comb begin
        status_word = '0;
        status_word[0] = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
        status_word[1] = done_q;
        status_word[2] = ovf_q;
        status_word[3] = fifo_empty;
        status_word[4] = fifo_full;
        status_word[ADDR_W+16:16] = count_q;
        ctrl_word = {16'b0, decim_q, 4'b0, irq_en_q, trig_en_q, 2'b0};
    end

    always_comb begin
        state_d      = state_q;
        trig_en_d    = trig_en_q;
        irq_en_d     = irq_en_q;
        decim_d      = decim_q;
        len_d        = len_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        captured_d   = captured_q;
        decim_cnt_d  = decim_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        rdata_d      = rdata_q;
        push_req     = 1'b0;
        push_ok      = 1'b0;
        pop          = 1'b0;

        if (iSample_tick) begin
            decim_cnt_d = tick_acc ? '0 : decim_cnt_q + 1'b1;
        end

        if (rd_en) begin
            rdata_d = '0;
            case (Address)
                A_CTRL:   rdata_d = ctrl_word;
                A_STATUS: rdata_d = status_word;
                A_DATA: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        rdata_d[DATA_W-1:0] = mem_q[rd_ptr_q];
                    end
                end
                default:  rdata_d[ADDR_W:0] = len_q;
            endcase
        end

        if (wr_en) begin
            case (Address)
                A_CTRL: begin
                    trig_en_d = WriteData[2];
                    irq_en_d  = WriteData[3];
                    decim_d   = WriteData[15:8];
                end
                A_STATUS: begin
                    if (WriteData[1]) done_d = 1'b0;
                    if (WriteData[2]) ovf_d  = 1'b0;
                end
                A_LEN:   len_d = WriteData[ADDR_W:0];
                default: ;
            endcase
        end

        // Hardware events are applied after W1C so a set on the same cycle is not lost.
        case (state_q)
            ST_ARMED: begin
                if (tick_acc) begin
                    if (trigger) begin
                        push_req = 1'b1;
                    end else begin
                        prev_d       = iData_sin;
                        prev_valid_d = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (tick_acc) push_req = 1'b1;
            end
            default: ;
        endcase

        if (push_req) begin
            captured_d = captured_inc;
            if (captured_inc == eff_len) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_CAPTURE;
            end
            if (!fifo_full || pop) begin
                push_ok = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        if (start_req && (state_q == ST_IDLE)) begin
            state_d      = WriteData[2] ? ST_ARMED : ST_CAPTURE;
            captured_d   = '0;
            done_d       = 1'b0;
            ovf_d        = 1'b0;
            decim_cnt_d  = '0;
            prev_valid_d = 1'b0;
        end

        if (clear_req) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            captured_d = '0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
            push_ok    = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            trig_en_q    <= 1'b0;
            irq_en_q     <= 1'b0;
            decim_q      <= '0;
            len_q        <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            captured_q   <= '0;
            decim_cnt_q  <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            trig_en_q    <= trig_en_d;
            irq_en_q     <= irq_en_d;
            decim_q      <= decim_d;
            len_q        <= len_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            captured_q   <= captured_d;
            decim_cnt_q  <= decim_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= iData_sin;
    end

    assign ReadData = rdata_q;
    assign oIrq     = done_q & irq_en_q;

endmodule
